// File: rtl/traffic_pkg.sv
// Shared phase encodings, lamp patterns and default timings
// for the demand-actuated intersection scheduler.
package traffic_pkg;

   typedef enum logic [2:0] {
      S_INIT = 3'd0,
      S_G1   = 3'd1,
      S_Y1   = 3'd2,
      S_CLR1 = 3'd3,
      S_G2   = 3'd4,
      S_Y2   = 3'd5,
      S_CLR2 = 3'd6
   } phase_e;

   // Lamp vectors are {R1, Y1, G1, R2, Y2, G2}
   localparam logic [5:0] LAMP_RED = 6'b100_100;
   localparam logic [5:0] LAMP_G1  = 6'b001_100;
   localparam logic [5:0] LAMP_Y1  = 6'b010_100;
   localparam logic [5:0] LAMP_G2  = 6'b100_001;
   localparam logic [5:0] LAMP_Y2  = 6'b100_010;

   localparam int DEF_CLK_DIV   = 1000;
   localparam int DEF_GREEN_MIN = 10;
   localparam int DEF_GREEN_MAX = 55;
   localparam int DEF_YELLOW_T  = 5;
   localparam int DEF_CLEAR_T   = 2;
   localparam int DEF_CNT_W     = 8;

   function automatic logic [5:0] lamp_of(input phase_e s);
      logic [5:0] l;
      l = LAMP_RED;
      unique case (s)
         S_G1:    l = LAMP_G1;
         S_Y1:    l = LAMP_Y1;
         S_G2:    l = LAMP_G2;
         S_Y2:    l = LAMP_Y2;
         default: l = LAMP_RED;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-clock tick every CLK_DIV clocks; clr restarts the count
// so a newly entered state always sees a full first second.
module sec_tick_gen #(
   parameter int CLK_DIV = 1000
) (
   input  logic Clk,
   input  logic Rst_n,
   input  logic clr,
   output logic tick
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div;

   assign tick = (div == LAST);

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         div <= '0;
      end else if (clr || tick) begin
         div <= '0;
      end else begin
         div <= div + DW'(1);
      end
   end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-road phase scheduler: demand latching, min/max green,
// all-red clearance and emergency preemption.
module traffic_phase_scheduler
   import traffic_pkg::*;
#(
   parameter int CLK_DIV   = DEF_CLK_DIV,
   parameter int GREEN_MIN = DEF_GREEN_MIN,
   parameter int GREEN_MAX = DEF_GREEN_MAX,
   parameter int YELLOW_T  = DEF_YELLOW_T,
   parameter int CLEAR_T   = DEF_CLEAR_T,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             en,
   input  logic             req1,
   input  logic             req2,
   input  logic             emg,
   input  logic             emg_dir,
   output logic             R1,
   output logic             Y1,
   output logic             G1,
   output logic             R2,
   output logic             Y2,
   output logic             G2,
   output logic [2:0]       phase,
   output logic [CNT_W-1:0] remain,
   output logic             emg_active
);

   localparam logic [CNT_W-1:0] T_MAX   = '1;
   localparam logic [CNT_W-1:0] CLR_D   = CNT_W'(CLEAR_T);
   localparam logic [CNT_W-1:0] YEL_D   = CNT_W'(YELLOW_T);
   localparam logic [CNT_W-1:0] CLR_END = CNT_W'(CLEAR_T - 1);
   localparam logic [CNT_W-1:0] YEL_END = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W:0]   N_MIN   = (CNT_W+1)'(GREEN_MIN);
   localparam logic [CNT_W:0]   N_MAX   = (CNT_W+1)'(GREEN_MAX);

   phase_e           state, state_n;
   logic [CNT_W-1:0] t, t_n, remain_n;
   logic [CNT_W:0]   n;
   logic [5:0]       lamp;
   logic             pend1, pend1_n, pend2, pend2_n;
   logic             emg_act_n;
   logic             tick, clr;
   logic             clr_done, yel_done, go1, go2;

   sec_tick_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_tick (
      .Clk  (Clk),
      .Rst_n(Rst_n),
      .clr  (clr),
      .tick (tick)
   );

   assign n        = {1'b0, t} + (CNT_W+1)'(1);
   assign clr_done = tick && (t == CLR_END);
   assign yel_done = tick && (t == YEL_END);
   assign go1 = tick && pend2 && ((n >= N_MIN && !req1) || n >= N_MAX);
   assign go2 = tick && pend1 && ((n >= N_MIN && !req2) || n >= N_MAX);

   always_comb begin
      state_n = state;
      unique case (state)
         S_INIT: if (clr_done) state_n = S_G1;
         S_G1: begin
            if ((emg && emg_dir) || (!emg && go1)) state_n = S_Y1;
         end
         S_Y1: if (yel_done) state_n = S_CLR1;
         S_CLR1: begin
            if (clr_done) state_n = (emg && !emg_dir) ? S_G1 : S_G2;
         end
         S_G2: begin
            if ((emg && !emg_dir) || (!emg && go2)) state_n = S_Y2;
         end
         S_Y2: if (yel_done) state_n = S_CLR2;
         S_CLR2: begin
            if (clr_done) state_n = (emg && emg_dir) ? S_G2 : S_G1;
         end
         default: state_n = S_INIT;
      endcase
      if (!en) state_n = S_INIT;
   end

   // Any state change restarts both the divider and the phase timer
   assign clr = !en || (state_n != state);

   always_comb begin
      t_n = t;
      if (clr) t_n = '0;
      else if (tick && t != T_MAX) t_n = t + CNT_W'(1);
   end

   assign pend1_n = en && state_n != S_G1 &&
                    (pend1 || (req1 && state != S_G1));
   assign pend2_n = en && state_n != S_G2 &&
                    (pend2 || (req2 && state != S_G2));

   assign emg_act_n = emg &&
                      ((state_n == S_G1 && !emg_dir) ||
                       (state_n == S_G2 && emg_dir));

   always_comb begin
      remain_n = '0;
      unique case (state_n)
         S_INIT, S_CLR1, S_CLR2: remain_n = CLR_D - t_n;
         S_Y1, S_Y2:             remain_n = YEL_D - t_n;
         default:                remain_n = '0;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state      <= S_INIT;
         t          <= '0;
         pend1      <= 1'b0;
         pend2      <= 1'b0;
         lamp       <= LAMP_RED;
         remain     <= CLR_D;
         emg_active <= 1'b0;
      end else begin
         state      <= state_n;
         t          <= t_n;
         pend1      <= pend1_n;
         pend2      <= pend2_n;
         lamp       <= lamp_of(state_n);
         remain     <= remain_n;
         emg_active <= emg_act_n;
      end
   end

   assign {R1, Y1, G1, R2, Y2, G2} = lamp;
   assign phase = state;

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Demand-actuated phase scheduler for a two-road intersection. Drives R1/Y1/G1 and R2/Y2/G2.
- Replaces the fixed 55 s / 5 s cycle of the two-light controller with:
  - vehicle/pedestrian request latching;
  - min/max green with own-road extension;
  - mandatory all-red clearance between phases;
  - emergency-vehicle preemption.
- Sits between the board inputs (buttons, sensors, enable switch) and the lamp outputs.

Parameters:
- CLK_DIV, 1000, Clk cycles per 1 s tick (1 kHz board clock).
- GREEN_MIN, 10, minimum green in ticks.
- GREEN_MAX, 55, maximum green in ticks while the opposing road has demand.
- YELLOW_T, 5, yellow duration in ticks.
- CLEAR_T, 2, all-red clearance duration in ticks; also the startup all-red duration.
- CNT_W, 8, width of the phase timer and the remain output.

Ports:
- Clk  in  1  system clock.
- Rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable; low forces all-red idle.
- req1  in  1  demand on road 1 (sensor or pedestrian button), level or pulse.
- req2  in  1  demand on road 2.
- emg  in  1  emergency preempt request, level.
- emg_dir  in  1  road granted by preempt: 0 = road 1, 1 = road 2.
- R1, Y1, G1, R2, Y2, G2  out  1 each  lamp drives, registered.
- phase  out  3  current state encoding.
- remain  out  CNT_W  ticks left in the current timed state; 0 in green.
- emg_active  out  1  high while a preempt green is being held.

Behaviour:
- States and encodings: S_INIT=0, S_G1=1, S_Y1=2, S_CLR1=3, S_G2=4, S_Y2=5, S_CLR2=6.
- Lamps per state:
  - INIT, CLR1, CLR2: R1=R2=1.
  - G1: G1, R2. Y1: Y1, R2.
  - G2: R1, G2. Y2: R1, Y2.
  - Exactly one lamp per road is lit at all times.
- Reset (Rst_n=0, async):
  - state=S_INIT, divider=0, timer t=0, pend1=pend2=0.
  - Outputs: R1=R2=1, all others 0, phase=0, remain=CLEAR_T, emg_active=0.
- en=0 (synchronous, checked every clock): same values as reset. Lamps show all-red on the next edge.
- Tick generation:
  - The divider counts 0..CLK_DIV-1; tick is a one-clock pulse when divider==CLK_DIV-1.
  - On every state entry the divider and t are cleared, so each timed state of duration D lasts exactly D*CLK_DIV clocks.
  - t increments on tick and saturates at 2^CNT_W-1.
- Timed states exit on the tick where t==D-1:
  - INIT (D=CLEAR_T) -> G1.
  - Y1 (YELLOW_T) -> CLR1.
  - Y2 (YELLOW_T) -> CLR2.
  - CLR1 (CLEAR_T) -> G2, unless emg && emg_dir==0, then -> G1.
  - CLR2 (CLEAR_T) -> G1, unless emg && emg_dir==1, then -> G2.
- Demand latching:
  - pend1 sets on req1 whenever state != G1; it clears on entry to G1.
  - pend2 is symmetric.
  - A request arriving in the entry cycle of its own green is not latched.
- Green G1 exit, evaluated on tick with n=t+1 (G2 is symmetric):
  - Go to Y1 if pend2 && n>=GREEN_MIN && !req1.
  - Go to Y1 if pend2 && n>=GREEN_MAX, regardless of req1.
  - With no opposing demand, rest in green indefinitely.
- Preemption:
  - emg && emg_dir targets the other road while in G1 or G2 -> go to yellow on the next clock, ignoring GREEN_MIN. The divider is cleared so the yellow lasts the full YELLOW_T.
  - emg targeting the current green -> hold green, no exits; emg_active=1.
  - Yellow and clearance are never shortened.
  - A change of emg_dir mid-preempt is handled by the same rules.
  - When emg drops, normal evaluation resumes at the next tick, using the accumulated t.
- remain:
  - Timed states: D-t.
  - Green: 0.
  - Registered together with state.

Decomposition:
- Package traffic_pkg: state encodings, lamp-vector constants per state, default durations.
- Sub-module sec_tick_gen: parameter CLK_DIV; inputs Clk, Rst_n, clr; output tick. Cleared on state entry and when en is low.

Test Plan (CLK_DIV=4, GREEN_MIN=3, GREEN_MAX=6, YELLOW_T=2, CLEAR_T=1):
1. Release reset with en=1 and no requests -> all-red for 4 clocks, then G1/R2, resting; phase=1 indefinitely.
2. In G1 at t=0, pulse req2 one clock, req1=0 -> Y1 after 12 clocks of G1, Y1 8 clocks, CLR1 4 clocks, then G2; pend2 cleared.
3. Hold req1=1 in G1 with pend2 set -> green lasts 24 clocks (GREEN_MAX), then Y1.
4. In G1 at t=1, raise emg with emg_dir=1 -> Y1 on the next clock, full 8 clocks, CLR1, G2 with emg_active=1; G2 held while emg stays high even with pend1 set.
5. In Y1 (heading to G2), assert emg with emg_dir=0 -> Y1 completes, CLR1 then G1 (not G2).
6. Drop en mid-Y2 -> all-red on the next edge, phase=0, remain=1. Assert Rst_n=0 asynchronously mid-G2 -> lamps go all-red without a clock edge.
